// File: rtl/wb_stage_if.sv
// Write-back stage bus bundle: MEM/WB latch inputs plus register-file write and forwarding outputs.
// Latency: none, this is wiring only.
// Backpressure: i_stall travels with the bundle; the stage owns the meaning of every signal.
interface wb_stage_if #(
    parameter int NB_BITS = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CNT  = 32
);
    // MEM/WB latch side
    logic [NB_BITS-1:0] i_mem_data;
    logic [NB_BITS-1:0] i_alu_data;
    logic [7:0]         i_wb_ctl;
    logic [NB_REG-1:0]  i_reg_dst;
    logic               i_stall;

    // Register file write port and forwarding copy
    logic [NB_BITS-1:0] o_wr_data;
    logic [NB_REG-1:0]  o_wr_addr;
    logic               o_wr_enable;
    logic [NB_BITS-1:0] o_fwd_data;
    logic [NB_REG-1:0]  o_fwd_addr;
    logic               o_fwd_valid;
    logic               o_misalign;
    logic [NB_CNT-1:0]  o_wr_count;

    // Upstream pipeline / test driver: drives the latch side, observes the results
    modport master (
        output i_mem_data, i_alu_data, i_wb_ctl, i_reg_dst, i_stall,
        input  o_wr_data, o_wr_addr, o_wr_enable, o_fwd_data, o_fwd_addr,
        input  o_fwd_valid, o_misalign, o_wr_count
    );

    // Write-back stage itself
    modport slave (
        input  i_mem_data, i_alu_data, i_wb_ctl, i_reg_dst, i_stall,
        output o_wr_data, o_wr_addr, o_wr_enable, o_fwd_data, o_fwd_addr,
        output o_fwd_valid, o_misalign, o_wr_count
    );
endinterface

// File: rtl/wb_stage.sv
// MIPS write-back: load lane extract/extend, mem/ALU select, alignment check, registered RF write + forward copy.
// Latency: 1 cycle, every output is registered. Optional write counter under WB_WRITE_COUNTER_EN.
// Backpressure: i_stall holds data/addr/misalign, forces write/forward strobes low; entry stays upstream.
module wb_stage #(
    parameter int NB_BITS = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CNT  = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    wb_stage_if.slave     bus
);

    // Decoded view of the WB control byte; bits [7:5] are reserved and never read.
    typedef struct packed {
        logic       is_unsigned;
        logic [1:0] size;
        logic       mem_to_reg;
        logic       reg_write;
    } wb_ctl_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    wb_ctl_t            ctl;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [NB_BITS-1:0] load_val;
    logic [NB_BITS-1:0] result_nxt;
    logic               misalign_nxt;
    logic               wr_en_nxt;

    logic [NB_BITS-1:0] wr_data_q;
    logic [NB_REG-1:0]  wr_addr_q;
    logic               wr_en_q;
    logic               misalign_q;

    // Decode control, pick the addressed lane, extend it and work out whether the write may commit.
    always_comb begin
        ctl.is_unsigned = bus.i_wb_ctl[4];
        ctl.size        = bus.i_wb_ctl[3:2];
        ctl.mem_to_reg  = bus.i_wb_ctl[1];
        ctl.reg_write   = bus.i_wb_ctl[0];

        case (bus.i_alu_data[1:0])
            2'd0:    byte_sel = bus.i_mem_data[7:0];
            2'd1:    byte_sel = bus.i_mem_data[15:8];
            2'd2:    byte_sel = bus.i_mem_data[23:16];
            default: byte_sel = bus.i_mem_data[31:24];
        endcase

        half_sel = bus.i_alu_data[1] ? bus.i_mem_data[31:16] : bus.i_mem_data[15:0];

        // Size 11 is treated as a word, same as 10.
        load_val = bus.i_mem_data;
        case (ctl.size)
            SZ_BYTE: load_val = ctl.is_unsigned ? {{(NB_BITS-8){1'b0}}, byte_sel}
                                                : {{(NB_BITS-8){byte_sel[7]}}, byte_sel};
            SZ_HALF: load_val = ctl.is_unsigned ? {{(NB_BITS-16){1'b0}}, half_sel}
                                                : {{(NB_BITS-16){half_sel[15]}}, half_sel};
            default: load_val = bus.i_mem_data;
        endcase

        result_nxt = ctl.mem_to_reg ? load_val : bus.i_alu_data;

        // Only loads that would actually write back are checked; bytes can never be misaligned.
        misalign_nxt = ctl.reg_write && ctl.mem_to_reg &&
                       (((ctl.size == SZ_HALF) && bus.i_alu_data[0]) ||
                        (ctl.size[1] && (bus.i_alu_data[1:0] != 2'b00)));

        // $0 is hardwired to zero, so it is never written.
        wr_en_nxt = ctl.reg_write && (bus.i_reg_dst != '0) && !misalign_nxt;
    end

    // Write-port register: reset clears, stall holds data but drops the strobe to avoid a double commit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else if (bus.i_stall) begin
            wr_en_q    <= 1'b0;
        end else begin
            wr_data_q  <= result_nxt;
            wr_addr_q  <= bus.i_reg_dst;
            wr_en_q    <= wr_en_nxt;
            misalign_q <= misalign_nxt;
        end
    end

    // The forwarding copy is the same flops as the write port, so the two can never disagree.
    assign bus.o_wr_data   = wr_data_q;
    assign bus.o_wr_addr   = wr_addr_q;
    assign bus.o_wr_enable = wr_en_q;
    assign bus.o_fwd_data  = wr_data_q;
    assign bus.o_fwd_addr  = wr_addr_q;
    assign bus.o_fwd_valid = wr_en_q;
    assign bus.o_misalign  = misalign_q;

`ifdef WB_WRITE_COUNTER_EN
    logic [NB_CNT-1:0] wr_cnt_q;

    // Count commits in step with the strobe being set; wraps naturally, frozen while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_cnt_q <= '0;
        end else if (!bus.i_stall && wr_en_nxt) begin
            wr_cnt_q <= wr_cnt_q + {{(NB_CNT-1){1'b0}}, 1'b1};
        end
    end

    assign bus.o_wr_count = wr_cnt_q;
`else
    assign bus.o_wr_count = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: stimulus pushes hand-computed expectations, a monitor pops and compares.
// Latency: expectation for an entry driven in cycle N is checked just after edge N+1.
// Backpressure: stall cycles push the held values as their expectation.
module tb_wb_stage;

    logic clk;
    logic rst;

    wb_stage_if #(.NB_BITS(32), .NB_REG(5), .NB_CNT(32)) bus ();

    wb_stage #(.NB_BITS(32), .NB_REG(5), .NB_CNT(32)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        en;
        logic        mis;
        logic [31:0] cnt;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] cnt_m  = 0;

    task automatic chk(input string tag, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %h, expected %h", tag, name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and record what the outputs must be after the next edge.
    task automatic drive(input string tag, input logic r, input logic st, input logic [7:0] ctl,
                         input logic [31:0] mem, input logic [31:0] alu, input logic [4:0] dst,
                         input logic [31:0] e_data, input logic [4:0] e_addr,
                         input logic e_en, input logic e_mis);
        exp_t e;
        @(posedge clk);
        #2;
        rst            = r;
        bus.i_stall    = st;
        bus.i_wb_ctl   = ctl;
        bus.i_mem_data = mem;
        bus.i_alu_data = alu;
        bus.i_reg_dst  = dst;
        if (r) cnt_m = 0;
        else if (e_en) cnt_m = cnt_m + 1;
        e.data = e_data;
        e.addr = e_addr;
        e.en   = e_en;
        e.mis  = e_mis;
`ifdef WB_WRITE_COUNTER_EN
        e.cnt  = cnt_m;
`else
        e.cnt  = 32'h0;
`endif
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, so compare whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.tag, "wr_data",   bus.o_wr_data,           e.data);
                chk(e.tag, "wr_addr",   {27'b0, bus.o_wr_addr},  {27'b0, e.addr});
                chk(e.tag, "wr_en",     {31'b0, bus.o_wr_enable}, {31'b0, e.en});
                chk(e.tag, "fwd_data",  bus.o_fwd_data,          e.data);
                chk(e.tag, "fwd_addr",  {27'b0, bus.o_fwd_addr}, {27'b0, e.addr});
                chk(e.tag, "fwd_valid", {31'b0, bus.o_fwd_valid}, {31'b0, e.en});
                chk(e.tag, "misalign",  {31'b0, bus.o_misalign}, {31'b0, e.mis});
                chk(e.tag, "wr_count",  bus.o_wr_count,          e.cnt);
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.i_stall    = 1'b0;
        bus.i_wb_ctl   = 8'h00;
        bus.i_mem_data = 32'h0;
        bus.i_alu_data = 32'h0;
        bus.i_reg_dst  = 5'd0;

        //     tag         rst   stall ctl    mem           alu           dst    e_data        e_addr e_en  e_mis
        drive("reset0",    1'b1, 1'b0, 8'h00, 32'h0,        32'h0,        5'd0,  32'h0,        5'd0,  1'b0, 1'b0);
        drive("reset1",    1'b1, 1'b0, 8'h00, 32'h0,        32'h0,        5'd0,  32'h0,        5'd0,  1'b0, 1'b0);
        drive("alu_op",    1'b0, 1'b0, 8'h01, 32'h0,        32'h0000_1234, 5'd5, 32'h0000_1234, 5'd5, 1'b1, 1'b0);
        drive("lb_s3",     1'b0, 1'b0, 8'h03, 32'h80FF_7F01, 32'h0000_1003, 5'd6, 32'hFFFF_FF80, 5'd6, 1'b1, 1'b0);
        drive("lbu_3",     1'b0, 1'b0, 8'h13, 32'h80FF_7F01, 32'h0000_1003, 5'd7, 32'h0000_0080, 5'd7, 1'b1, 1'b0);
        drive("lh_hi",     1'b0, 1'b0, 8'h07, 32'h8001_0000, 32'h0000_2002, 5'd8, 32'hFFFF_8001, 5'd8, 1'b1, 1'b0);
        drive("lh_mis",    1'b0, 1'b0, 8'h07, 32'h8001_0000, 32'h0000_2001, 5'd8, 32'h0000_0000, 5'd8, 1'b0, 1'b1);
        drive("stall_mis", 1'b0, 1'b1, 8'h01, 32'h0,        32'h0000_0777, 5'd3, 32'h0000_0000, 5'd8, 1'b0, 1'b1);
        drive("wr_r0",     1'b0, 1'b0, 8'h01, 32'h0,        32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
        drive("lw_mis",    1'b0, 1'b0, 8'h0B, 32'h1234_5678, 32'h0000_4002, 5'd9, 32'h1234_5678, 5'd9, 1'b0, 1'b1);
        drive("lw_sz11",   1'b0, 1'b0, 8'h0F, 32'hCAFE_F00D, 32'h0000_4000, 5'd10, 32'hCAFE_F00D, 5'd10, 1'b1, 1'b0);
        drive("rsvd_ctl",  1'b0, 1'b0, 8'hE5, 32'hFFFF_FFFF, 32'h0000_3001, 5'd11, 32'h0000_3001, 5'd11, 1'b1, 1'b0);
        drive("lh_lo",     1'b0, 1'b0, 8'h07, 32'h1234_F00D, 32'h0000_0000, 5'd12, 32'hFFFF_F00D, 5'd12, 1'b1, 1'b0);
        drive("lbu_1",     1'b0, 1'b0, 8'h13, 32'h80FF_7F01, 32'h0000_0001, 5'd13, 32'h0000_007F, 5'd13, 1'b1, 1'b0);
        drive("lb_s2",     1'b0, 1'b0, 8'h03, 32'h80FF_7F01, 32'h0000_0002, 5'd14, 32'hFFFF_FFFF, 5'd14, 1'b1, 1'b0);
        drive("ld_norw",   1'b0, 1'b0, 8'h02, 32'h80FF_7F01, 32'h0000_0003, 5'd15, 32'hFFFF_FF80, 5'd15, 1'b0, 1'b0);
        drive("lh_norw",   1'b0, 1'b0, 8'h06, 32'h80FF_7F01, 32'h0000_0001, 5'd15, 32'h0000_7F01, 5'd15, 1'b0, 1'b0);
        drive("pre_stall", 1'b0, 1'b0, 8'h01, 32'h0,        32'h0000_AAAA, 5'd17, 32'h0000_AAAA, 5'd17, 1'b1, 1'b0);
        drive("stall1",    1'b0, 1'b1, 8'h01, 32'h0,        32'h0000_5555, 5'd16, 32'h0000_AAAA, 5'd17, 1'b0, 1'b0);
        drive("stall2",    1'b0, 1'b1, 8'h01, 32'h0,        32'h0000_5555, 5'd16, 32'h0000_AAAA, 5'd17, 1'b0, 1'b0);
        drive("release",   1'b0, 1'b0, 8'h01, 32'h0,        32'h0000_5555, 5'd16, 32'h0000_5555, 5'd16, 1'b1, 1'b0);
        drive("stall3",    1'b0, 1'b1, 8'h01, 32'h0,        32'h0000_6666, 5'd18, 32'h0000_5555, 5'd16, 1'b0, 1'b0);
        drive("rst_stall", 1'b1, 1'b1, 8'h01, 32'h0,        32'h0000_6666, 5'd18, 32'h0,         5'd0,  1'b0, 1'b0);
        drive("post_rst",  1'b0, 1'b0, 8'h01, 32'h0,        32'h0000_0007, 5'd1,  32'h0000_0007, 5'd1, 1'b1, 1'b0);

        // Let the last expectation drain through the monitor, with a bounded wait.
        @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage MIPS pipeline.
- Consumes the MEM/WB latch outputs: memory read data, ALU result/address, 8-bit WB control byte and destination register.
- Performs load lane extraction with sign/zero extension, selects memory vs ALU result, checks load alignment, and drives a registered write port into the register file.
- Provides a registered forwarding copy for the hazard/forwarding unit.

Parameters:
- NB_BITS, 32, datapath width (only 32 supported).
- NB_REG, 5, register address width.
- NB_CNT, 32, width of the register-write counter (optional feature).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active high.
- i_mem_data  in  NB_BITS  word read from data memory (MEM/WB latch).
- i_alu_data  in  NB_BITS  ALU result; also the load address.
- i_wb_ctl  in  8  control: [0] reg_write, [1] mem_to_reg, [3:2] load size (00 byte, 01 half, 10 word, 11 = word), [4] unsigned load, [7:5] reserved/ignored.
- i_reg_dst  in  NB_REG  destination register.
- i_stall  in  1  hold request from the debug unit/hazard control.
- o_wr_data  out  NB_BITS  register file write data.
- o_wr_addr  out  NB_REG  register file write address.
- o_wr_enable  out  1  register file write strobe.
- o_fwd_data  out  NB_BITS  same value as o_wr_data, for forwarding.
- o_fwd_addr  out  NB_REG  same value as o_wr_addr.
- o_fwd_valid  out  1  forward entry valid.
- o_misalign  out  1  misaligned load detected on the last accepted entry.
- o_wr_count  out  NB_CNT  number of committed register writes (optional feature).

Behaviour:
- Single clock domain; all outputs are registered.
- Reset: all outputs 0 at the first posedge with i_rst=1, including o_wr_count. Reset overrides i_stall. Reset mid-stream drops the in-flight entry; no write occurs.
- Latency: inputs presented at edge N appear on outputs after edge N (1 cycle).
- Byte lane = i_alu_data[1:0], little-endian: byte k = i_mem_data[8k+7:8k].
- Halfword: i_alu_data[1]=0 selects [15:0]; i_alu_data[1]=1 selects [31:16].
- Word: full i_mem_data.
- Extension:
  - unsigned=1: zero-extend.
  - unsigned=0: sign-extend from bit 7 (byte) or bit 15 (half).
  - Ignored for word loads.
- Result select: mem_to_reg=1 -> extracted load value; mem_to_reg=0 -> i_alu_data.
- Misalign condition: reg_write=1 and mem_to_reg=1, and either (half with addr[0]=1) or (word with addr[1:0]!=0).
- On misalign:
  - o_misalign=1 for that cycle.
  - o_wr_enable=0 and o_fwd_valid=0.
  - o_wr_data/o_wr_addr still register the computed value.
- Write enable: o_wr_enable = reg_write AND i_reg_dst!=0 AND NOT misalign. o_fwd_valid is the same signal.
- Register $0: writes to $0 are never enabled, but data/address are still registered.
- Stall (i_stall=1, no reset):
  - o_wr_data, o_wr_addr, o_fwd_data, o_fwd_addr and o_misalign hold their values.
  - o_wr_enable and o_fwd_valid are forced 0, so no double commit.
  - The counter holds.
  - The input entry is not consumed; the upstream pipeline holds it.
- Reserved ctl bits [7:5] have no effect.

Optional Feature:
- Macro WB_WRITE_COUNTER_EN.
- Defined: o_wr_count increments by 1 on every edge where o_wr_enable is set to 1 for the next cycle. Wraps modulo 2^NB_CNT. Cleared by reset; held on stall. Read by the debug unit.
- Undefined: no counter logic is synthesized and o_wr_count is tied to 0.

Test Plan:
- Reset for 2 cycles, then release -> all outputs 0 and o_wr_count=0.
- ALU op: ctl=0x01, alu=0x0000_1234, dst=5 -> next cycle wr_en=1, addr=5, data=0x0000_1234, fwd_valid=1.
- Signed byte load: ctl=0x03, mem=0x80FF_7F01, alu addr=0x...3 -> data=0xFFFF_FF80. Same with ctl=0x13 (unsigned) -> data=0x0000_0080.
- Half load at addr 0x...2, ctl=0x07, mem=0x8001_0000 -> data=0xFFFF_8001. Same at addr 0x...1 -> o_misalign=1, wr_en=0.
- Write to $0: ctl=0x01, dst=0, alu=0xDEAD_BEEF -> wr_en=0, wr_data=0xDEAD_BEEF, counter unchanged.
- Stall and counter:
  - Commit 3 writes -> o_wr_count=3.
  - Assert i_stall for 2 cycles with a new valid entry held -> wr_en=0, outputs held, count stays 3.
  - Release -> entry commits once, count=4.
  - Assert i_rst during stall -> all outputs 0 next edge.
